adc_sample_averager: RTL and testbench
======================================

Name: adc_sample_averager

Overview:
- Sits directly downstream of the dual modular-ADC subsystem.
- Consumes the ADC sequencer response stream, one sample per valid beat.
- Accumulates 2^LOG2_N samples per channel and emits one averaged result per channel per window on a valid/ready output stream for the NIOS-side reader.
- Gates all activity on the ADC PLL lock and discards partial windows when lock is lost.

Parameters:
- NUM_CH, 8, number of averaged channels, 1..16.
- CH_BASE, 1, ADC channel number mapped to accumulator slot 0.
- LOG2_N, 4, log2 of samples per window, 1..8.
- LOCK_CYCLES, 256, consecutive locked cycles required before sampling starts, >=2.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- pll_locked_export  in  1  ADC PLL locked, already synchronous to clk_clk.
- rsp_valid  in  1  sample beat valid; there is no backpressure to the ADC.
- rsp_channel  in  5  ADC channel of the sample.
- rsp_data  in  12  unsigned sample.
- avg_valid  out  1  result available.
- avg_ready  in  1  consumer accepts the result.
- avg_channel  out  5  ADC channel of the result.
- avg_data  out  12  averaged value.
- overrun  out  1  sticky flag: a result was dropped.
- drop_count  out  16  number of dropped results, saturating.
- running  out  1  high in RUN state.

Behaviour:
- Reset values: all outputs 0; state WAIT_LOCK; all accumulators, sample counters and lock counter cleared.
- States:
  - WAIT_LOCK: lock counter increments each cycle pll_locked_export=1 and clears on 0. When the count reaches LOCK_CYCLES-1 with lock still high, go to RUN next cycle. rsp beats are ignored.
  - RUN: running=1. If pll_locked_export=0, go to FLUSH next cycle. A beat arriving in that same cycle is ignored.
  - FLUSH: one cycle. Clear all accumulators, sample counters and the lock counter, then go to WAIT_LOCK. The output register and any pending avg_valid are preserved.
- Slot mapping: slot = rsp_channel - CH_BASE. Beats with rsp_channel < CH_BASE or >= CH_BASE+NUM_CH are ignored with no side effects.
- Accumulator width is 12+LOG2_N bits, so overflow cannot occur. The per-slot sample counter is LOG2_N bits and wraps.
- Accepted beat, slot counter != 2^LOG2_N-1: acc += rsp_data; counter += 1.
- Accepted beat, slot counter == 2^LOG2_N-1 (window complete):
  - result = (acc + rsp_data) >> LOG2_N, truncating.
  - acc and counter for that slot reset to 0 in the same cycle.
  - The result is offered to the output register.
- Output register (single entry):
  - If empty, or avg_valid && avg_ready in the same cycle, the result loads. avg_valid=1, avg_channel, avg_data valid the cycle after the completing beat (latency 1).
  - If full and not being accepted, the new result is dropped: overrun<=1, drop_count+=1, saturating at 16'hFFFF. The held result is unchanged.
- Handshake:
  - Transfer occurs when avg_valid && avg_ready.
  - avg_valid must not drop and avg_channel/avg_data must not change until the transfer.
  - After a transfer with no new load, avg_valid=0 the next cycle.
  - avg_ready may be high with avg_valid low; this has no effect.
- Back-to-back beats, one per cycle on any mix of channels, must be accepted without loss of accumulation.
- overrun and drop_count clear only on reset.
- Asynchronous reset mid-window discards all partial sums and any held result.

Test Plan:
- Lock sequencing: reset, hold pll_locked_export=1 -> running=1 exactly LOCK_CYCLES cycles after lock asserts. A lock glitch at cycle 100 restarts the count.
- Basic average: defaults, avg_ready=1, 16 beats on channel 1 with data 0..15 -> one result, avg_channel=1, avg_data=7, avg_valid one cycle after the 16th beat.
- Full scale: 16 beats of 12'hFFF on channel 8 -> avg_data=12'hFFF. Channel 0 and channel 9 beats interleaved throughout -> no effect on the result.
- Backpressure: avg_ready=0, complete windows on channels 2 then 3 -> channel 2 result held stable, overrun=1, drop_count=1. Then avg_ready=1 -> channel 2 transferred, avg_valid=0 the next cycle.
- Interleaving: alternate channels 1/2 every cycle, 32 beats, data ch1=100, ch2=200 -> results (1,100) and (2,200), in the order their windows complete.
- Lock loss: 10 beats on channel 1, drop lock, FLUSH, re-lock, then 16 beats of 50 -> avg_data=50, no contamination from the earlier partial window.

Source files
------------

// File: rtl/adc_sample_averager.sv
// Per-channel windowed averager for the modular-ADC response stream.
// Results leave through a single-entry valid/ready register; overflowing results are counted and dropped.
module adc_sample_averager #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_BASE     = 1,
  parameter int unsigned LOG2_N      = 4,
  parameter int unsigned LOCK_CYCLES = 256
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        pll_locked_export,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  output logic        avg_valid,
  input  logic        avg_ready,
  output logic [4:0]  avg_channel,
  output logic [11:0] avg_data,
  output logic        overrun,
  output logic [15:0] drop_count,
  output logic        running
);

  localparam int unsigned ACC_W  = 12 + LOG2_N;
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {WAIT_LOCK, RUN, FLUSH} state_t;

  state_t state, state_nxt;

  logic [LOCK_W-1:0] lock_cnt;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [LOG2_N-1:0] cnt [NUM_CH];

  logic              accept;
  logic [NUM_CH-1:0] slot_hit;
  logic [ACC_W-1:0]  sel_acc;
  logic [LOG2_N-1:0] sel_cnt;
  logic [ACC_W-1:0]  sum;
  logic              window_done;
  logic              load;
  logic              drop;
  logic              lock_done;

  assign lock_done = (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= WAIT_LOCK;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (pll_locked_export && lock_done) state_nxt = RUN;
      RUN:       if (!pll_locked_export) state_nxt = FLUSH;
      FLUSH:     state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    running = (state == RUN);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lock_cnt <= '0;
    end else if (state == FLUSH) begin
      lock_cnt <= '0;
    end else if (state == WAIT_LOCK) begin
      if (!pll_locked_export)  lock_cnt <= '0;
      else if (!lock_done)     lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Out-of-range channels simply never match a slot, so they leave no trace.
  assign accept = (state == RUN) && pll_locked_export && rsp_valid;

  always_comb begin
    slot_hit = '0;
    sel_acc  = '0;
    sel_cnt  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot_hit[i] = accept && ({1'b0, rsp_channel} == 6'(CH_BASE + i));
      if (slot_hit[i]) begin
        sel_acc = acc[i];
        sel_cnt = cnt[i];
      end
    end
  end

  assign sum         = sel_acc + ACC_W'(rsp_data);
  assign window_done = (|slot_hit) && (sel_cnt == '1);
  assign load        = window_done && (!avg_valid || avg_ready);
  assign drop        = window_done && avg_valid && !avg_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (state == FLUSH) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (slot_hit[i]) begin
          if (window_done) begin
            acc[i] <= '0;
            cnt[i] <= '0;
          end else begin
            acc[i] <= sum;
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Output register is independent of the FSM so a held result survives FLUSH.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avg_valid   <= 1'b0;
      avg_channel <= '0;
      avg_data    <= '0;
    end else if (load) begin
      avg_valid   <= 1'b1;
      avg_channel <= rsp_channel;
      avg_data    <= sum[ACC_W-1:LOG2_N];
    end else if (avg_ready) begin
      avg_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager at default parameters.
module tb_adc_sample_averager;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        pll_locked_export;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        avg_valid;
  logic        avg_ready;
  logic [4:0]  avg_channel;
  logic [11:0] avg_data;
  logic        overrun;
  logic [15:0] drop_count;
  logic        running;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  adc_sample_averager #(
    .NUM_CH(8), .CH_BASE(1), .LOG2_N(4), .LOCK_CYCLES(256)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .pll_locked_export(pll_locked_export),
    .rsp_valid(rsp_valid),
    .rsp_channel(rsp_channel),
    .rsp_data(rsp_data),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .avg_channel(avg_channel),
    .avg_data(avg_data),
    .overrun(overrun),
    .drop_count(drop_count),
    .running(running)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [4:0] ch, input logic [11:0] d);
    rsp_valid   = 1'b1;
    rsp_channel = ch;
    rsp_data    = d;
    tick();
    rsp_valid   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] ch, input logic [11:0] d);
    chk({tag, "_valid"}, 32'(avg_valid), 32'(v));
    chk({tag, "_chan"},  32'(avg_channel), 32'(ch));
    chk({tag, "_data"},  32'(avg_data), 32'(d));
  endtask

  initial begin
    reset_reset_n     = 1'b0;
    pll_locked_export = 1'b0;
    rsp_valid         = 1'b0;
    rsp_channel       = '0;
    rsp_data          = '0;
    avg_ready         = 1'b0;
    #12;
    chk_out("rst", 1'b0, 5'd0, 12'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    reset_reset_n = 1'b1;
    tick();

    // Lock sequencing with a glitch at cycle 100
    pll_locked_export = 1'b1;
    repeat (100) tick();
    chk("lock_100", 32'(running), 32'd0);
    pll_locked_export = 1'b0;
    tick();
    pll_locked_export = 1'b1;
    repeat (255) tick();
    chk("lock_255", 32'(running), 32'd0);
    tick();
    chk("lock_256", 32'(running), 32'd1);

    // Basic average: 0..15 on channel 1 -> 120/16 = 7
    avg_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat(5'd1, 12'(i));
      if (i == 14) chk("basic_early", 32'(avg_valid), 32'd0);
    end
    chk_out("basic", 1'b1, 5'd1, 12'd7);
    tick();
    chk("basic_drain", 32'(avg_valid), 32'd0);

    // Full scale on channel 8 with out-of-range channels 0 and 9 interleaved
    for (int i = 0; i < 15; i++) begin
      beat(5'd0, 12'd123);
      beat(5'd8, 12'hFFF);
      beat(5'd9, 12'd55);
    end
    beat(5'd0, 12'd1);
    beat(5'd9, 12'd2);
    chk("full_early", 32'(avg_valid), 32'd0);
    beat(5'd8, 12'hFFF);
    chk_out("full", 1'b1, 5'd8, 12'hFFF);
    tick();

    // Backpressure: ch2 (0,10,..,150 -> 75) held, ch3 window dropped
    avg_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(5'd2, 12'(i * 10));
    chk_out("bp_ch2", 1'b1, 5'd2, 12'd75);
    for (int i = 0; i < 16; i++) beat(5'd3, 12'd300);
    chk_out("bp_hold", 1'b1, 5'd2, 12'd75);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_drops", 32'(drop_count), 32'd1);
    avg_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(avg_valid), 32'd0);

    // Interleave channels 1 and 2 every cycle
    for (int i = 0; i < 15; i++) begin
      beat(5'd1, 12'd100);
      beat(5'd2, 12'd200);
    end
    beat(5'd1, 12'd100);
    chk_out("il_ch1", 1'b1, 5'd1, 12'd100);
    beat(5'd2, 12'd200);
    chk_out("il_ch2", 1'b1, 5'd2, 12'd200);
    tick();
    chk("il_drain", 32'(avg_valid), 32'd0);

    // Lock loss discards a partial window on channel 1
    for (int i = 0; i < 10; i++) beat(5'd1, 12'd1000);
    pll_locked_export = 1'b0;
    beat(5'd1, 12'hFFF);
    chk("loss_flush_running", 32'(running), 32'd0);
    tick();
    pll_locked_export = 1'b1;
    repeat (256) tick();
    chk("relock_running", 32'(running), 32'd1);
    for (int i = 0; i < 16; i++) begin
      beat(5'd1, 12'd50);
      if (i == 5) chk("relock_no_early", 32'(avg_valid), 32'd0);
    end
    chk_out("relock", 1'b1, 5'd1, 12'd50);
    chk("sticky_overrun", 32'(overrun), 32'd1);
    chk("sticky_drops", 32'(drop_count), 32'd1);
    tick();

    // Reset discards a held result and the sticky flags
    avg_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(5'd4, 12'd8);
    chk_out("held", 1'b1, 5'd4, 12'd8);
    reset_reset_n = 1'b0;
    #1;
    chk_out("rst2", 1'b0, 5'd0, 12'd0);
    chk("rst2_overrun", 32'(overrun), 32'd0);
    chk("rst2_drops", 32'(drop_count), 32'd0);
    chk("rst2_running", 32'(running), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
